booth_mul_pipe: RTL and testbench

- Parametrised, pipelined radix-4 Booth / Wallace-tree integer multiplier for the datapath.
- Supports all four RISC-V M-extension multiply ops (MUL, MULH, MULHSU, MULHU) at operand width W.
- Uses valid/ready handshakes with full back-pressure and carries an opaque tag alongside each operation.
- Sits between the issue stage and the writeback arbiter; sustains one op per cycle when not stalled.

---
 rtl/booth_mul_pkg.sv | 50 +++++
 rtl/booth_mul_pipe_pp_gen.sv | 32 +++
 rtl/booth_mul_pipe.sv | 165 ++++++++++++++++
 tb/tb_booth_mul_pipe.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mul_pkg.sv
// Shared types and elaboration-time helpers for the radix-4 Booth multiplier.
package booth_mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULH   = 2'd1,
    OP_MULHSU = 2'd2,
    OP_MULHU  = 2'd3
  } mul_op_e;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  function automatic int npp(input int w);
    return w / 2 + 1;
  endfunction

  // Row count after a given number of 3:2 layers; leftover rows pass through.
  function automatic int csa_rows(input int n0, input int lvl);
    int n;
    n = n0;
    for (int i = 0; i < lvl; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int csa_levels(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + n % 3;
      l++;
    end
    return l;
  endfunction

  // bits = {b[2i+1], b[2i], b[2i-1]}; -0 is encoded as zero so no inject bit fires.
  function automatic booth_digit_t booth_dec(input logic [2:0] bits);
    booth_digit_t d;
    d.one = bits[1] ^ bits[0];
    d.two = (bits == 3'b011) || (bits == 3'b100);
    d.neg = bits[2] & ~(bits[1] & bits[0]);
    return d;
  endfunction

endpackage

// File: rtl/booth_mul_pipe_pp_gen.sv
// Radix-4 Booth partial-product generator: one shifted row per digit plus its negation inject bit.
module booth_pp_gen
  import booth_mul_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W+1:0]   i_a,
  input  logic [W+1:0]   i_b,
  output logic [2*W+1:0] o_pp [npp(W)],
  output logic [npp(W)-1:0] o_neg
);

  localparam int NPP = npp(W);
  localparam int PW  = 2 * W + 2;

  logic [W+2:0]  w_b_pad;
  logic [PW-1:0] w_a_sx;

  assign w_b_pad = {i_b, 1'b0};
  assign w_a_sx  = {{W{i_a[W+1]}}, i_a};

  // A negative row is the one's complement here; the +1 arrives via o_neg at bit 2i.
  for (genvar i = 0; i < NPP; i++) begin : g_pp
    booth_digit_t  w_dig;
    logic [PW-1:0] w_mag;
    assign w_dig    = booth_dec(w_b_pad[2*i+2:2*i]);
    assign w_mag    = w_dig.two ? (w_a_sx << 1) : (w_dig.one ? w_a_sx : '0);
    assign o_pp[i]  = (w_dig.neg ? ~w_mag : w_mag) << (2 * i);
    assign o_neg[i] = w_dig.neg;
  end

endmodule

// File: rtl/booth_mul_pipe.sv
// Three-stage radix-4 Booth / Wallace multiplier for RISC-V MUL/MULH/MULHSU/MULHU.
// Optional flush port and logic are built only when BOOTH_MUL_FLUSH_EN is defined.
module booth_mul_pipe
  import booth_mul_pkg::*;
#(
  parameter int W     = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  mul_op_e          in_op,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
`ifdef BOOTH_MUL_FLUSH_EN
  input  logic             flush,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NPP  = npp(W);
  localparam int PW   = 2 * W + 2;
  localparam int N0   = NPP + 1;
  localparam int NLVL = csa_levels(N0);
  localparam int LCUT = (NLVL + 2) / 3;

  logic             r_vld_p1, r_vld_p2, r_vld_p3;
  mul_op_e          r_op_p1, r_op_p2;
  logic [TAG_W-1:0] r_tag_p1, r_tag_p2, r_tag_p3;
  logic [W-1:0]     r_res_p3;
  logic signed [PW-1:0] r_sum_p2, r_car_p2;

  logic w_stall, w_en, w_acc;

  // Bubbles never collapse, so the whole pipe shares one enable.
  assign w_stall = r_vld_p3 & ~out_ready;
  assign w_en    = ~w_stall;
`ifdef BOOTH_MUL_FLUSH_EN
  assign in_ready = ~w_stall & ~flush;
`else
  assign in_ready = ~w_stall;
`endif
  assign w_acc = in_valid & in_ready;

  // ---- stage 0: operand extension, Booth rows, first CSA layers ----
  logic          w_sa, w_sb;
  logic [W+1:0]  w_a_ext, w_b_ext;
  logic [PW-1:0] w_pp [NPP];
  logic [NPP-1:0] w_neg;
  logic [PW-1:0] w_inj;

  assign w_sa    = (in_op == OP_MULH) || (in_op == OP_MULHSU);
  assign w_sb    = (in_op == OP_MULH);
  assign w_a_ext = {{2{w_sa & in_a[W-1]}}, in_a};
  assign w_b_ext = {{2{w_sb & in_b[W-1]}}, in_b};

  booth_pp_gen #(.W(W)) u_pp (
    .i_a  (w_a_ext),
    .i_b  (w_b_ext),
    .o_pp (w_pp),
    .o_neg(w_neg)
  );

  always_comb begin
    w_inj = '0;
    for (int i = 0; i < NPP; i++) w_inj[2*i] = w_neg[i];
  end

  for (genvar l = 0; l <= NLVL; l++) begin : g_lvl
    localparam int N = csa_rows(N0, l);
    logic [PW-1:0] w_rows [N];
    if (l == 0) begin : g_src
      for (genvar i = 0; i < NPP; i++) begin : g_cp
        assign w_rows[i] = w_pp[i];
      end
      assign w_rows[NPP] = w_inj;
    end else begin : g_red
      localparam int NP = csa_rows(N0, l - 1);
      localparam int NG = NP / 3;
      logic [PW-1:0] w_red [N];
      for (genvar g = 0; g < NG; g++) begin : g_csa
        logic [PW-1:0] w_x, w_y, w_z;
        assign w_x = g_lvl[l-1].w_rows[3*g];
        assign w_y = g_lvl[l-1].w_rows[3*g+1];
        assign w_z = g_lvl[l-1].w_rows[3*g+2];
        assign w_red[2*g]   = w_x ^ w_y ^ w_z;
        assign w_red[2*g+1] = ((w_x & w_y) | (w_x & w_z) | (w_y & w_z)) << 1;
      end
      for (genvar r = 0; r < NP % 3; r++) begin : g_pass
        assign w_red[2*NG+r] = g_lvl[l-1].w_rows[3*NG+r];
      end
      // ---- P1 boundary: partially reduced rows ----
      if (l == LCUT) begin : g_cut
        logic [PW-1:0] r_rows_p1 [N];
        always_ff @(posedge clk) begin
          if (w_en) for (int i = 0; i < N; i++) r_rows_p1[i] <= w_red[i];
        end
        for (genvar i = 0; i < N; i++) begin : g_out
          assign w_rows[i] = r_rows_p1[i];
        end
      end else begin : g_comb
        for (genvar i = 0; i < N; i++) begin : g_out
          assign w_rows[i] = w_red[i];
        end
      end
    end
  end

  // ---- P2 boundary: final sum/carry rows ----
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_op_p1  <= in_op;
      r_tag_p1 <= in_tag;
      r_op_p2  <= r_op_p1;
      r_tag_p2 <= r_tag_p1;
      r_sum_p2 <= $signed(g_lvl[NLVL].w_rows[0]);
      r_car_p2 <= $signed(g_lvl[NLVL].w_rows[1]);
    end
  end

  // ---- stage 2: carry-propagate add and half select ----
  logic signed [PW-1:0] w_prod;
  logic [W-1:0]         w_res;
  logic [1:0]           w_unused_hi;

  assign w_prod      = r_sum_p2 + r_car_p2;
  assign w_res       = (r_op_p2 == OP_MUL) ? w_prod[W-1:0] : w_prod[2*W-1:W];
  assign w_unused_hi = w_prod[PW-1:2*W];

  // ---- P3 boundary: output register and all valid bits ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
      r_res_p3 <= '0;
      r_tag_p3 <= '0;
    end else begin
`ifdef BOOTH_MUL_FLUSH_EN
      if (flush) begin
        r_vld_p1 <= 1'b0;
        r_vld_p2 <= 1'b0;
        r_vld_p3 <= 1'b0;
      end else
`endif
      if (w_en) begin
        r_vld_p1 <= w_acc;
        r_vld_p2 <= r_vld_p1;
        r_vld_p3 <= r_vld_p2;
        r_res_p3 <= w_res;
        r_tag_p3 <= r_tag_p2;
      end
    end
  end

  assign out_valid  = r_vld_p3;
  assign out_result = r_res_p3;
  assign out_tag    = r_tag_p3;

endmodule

// File: tb/tb_booth_mul_pipe.sv
// Bench for booth_mul_pipe at W=64 and W=16: directed cases plus random traffic vs. a wide-integer model.
module tb_booth_mul_pipe;
  import booth_mul_pkg::*;

  localparam int NRAND = 10000;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  mul_op_e     in_op;
  logic [63:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  mul_op_e     s_in_op;
  logic [15:0] s_in_a, s_in_b, s_out_result;
  logic [4:0]  s_in_tag, s_out_tag;

  logic fl64;
`ifdef BOOTH_MUL_FLUSH_EN
  logic flush;
  logic s_flush;
  assign fl64 = flush;
`else
  assign fl64 = 1'b0;
`endif

  booth_mul_pipe #(.W(64), .TAG_W(5)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
`ifdef BOOTH_MUL_FLUSH_EN
    .flush(flush),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  booth_mul_pipe #(.W(16), .TAG_W(5)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op),
    .in_a(s_in_a), .in_b(s_in_b), .in_tag(s_in_tag),
`ifdef BOOTH_MUL_FLUSH_EN
    .flush(s_flush),
`endif
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_result(s_out_result), .out_tag(s_out_tag)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_acc64 = 0;
  int n_acc16 = 0;
  exp_t q64[$];
  exp_t q16[$];

  task automatic check_eq(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Exact product of the w-bit operands interpreted per op, then the requested half.
  function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
    logic signed [129:0] ax, bx, p, hi;
    logic [63:0] mask;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    ax = $signed({66'd0, a & mask});
    bx = $signed({66'd0, b & mask});
    if ((op == 2'd1 || op == 2'd2) && a[w-1]) ax = ax - (130'sd1 <<< w);
    if (op == 2'd1 && b[w-1]) bx = bx - (130'sd1 <<< w);
    p  = ax * bx;
    hi = p >>> w;
    return (op == 2'd0) ? (p[63:0] & mask) : (hi[63:0] & mask);
  endfunction

  function automatic logic [63:0] rnd_opnd(input int w);
    logic [63:0] mask;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return mask;
      2: return 64'd1 << (w - 1);
      3: return mask >> 1;
      4: return 64'd1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  logic        h64_v = 1'b0;
  logic [63:0] h64_res;
  logic [4:0]  h64_tag;
  always @(negedge clk) begin
    if (rst || fl64) begin
      q64.delete();
      h64_v = 1'b0;
    end else begin
      if (h64_v) begin
        check_eq("hold64_vld", 64'(out_valid), 64'd1);
        check_eq("hold64_res", out_result, h64_res);
        check_eq("hold64_tag", 64'(out_tag), 64'(h64_tag));
      end
      if (out_valid && out_ready) begin
        if (q64.size() == 0) check_eq("spurious64", 64'(q64.size()), 64'd1);
        else begin
          exp_t e;
          e = q64.pop_front();
          check_eq("sb64_res", out_result, e.res);
          check_eq("sb64_tag", 64'(out_tag), 64'(e.tag));
        end
      end
      if (in_valid && in_ready) begin
        q64.push_back('{ref_mul(in_op, in_a, in_b, 64), in_tag});
        n_acc64++;
      end
      h64_v   = out_valid && !out_ready;
      h64_res = out_result;
      h64_tag = out_tag;
    end
  end

  logic        h16_v = 1'b0;
  logic [15:0] h16_res;
  logic [4:0]  h16_tag;
  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
      h16_v = 1'b0;
    end else begin
      if (h16_v) begin
        check_eq("hold16_res", 64'(s_out_result), 64'(h16_res));
        check_eq("hold16_tag", 64'(s_out_tag), 64'(h16_tag));
      end
      if (s_out_valid && s_out_ready) begin
        if (q16.size() == 0) check_eq("spurious16", 64'(q16.size()), 64'd1);
        else begin
          exp_t e;
          e = q16.pop_front();
          check_eq("sb16_res", 64'(s_out_result), e.res);
          check_eq("sb16_tag", 64'(s_out_tag), 64'(e.tag));
        end
      end
      if (s_in_valid && s_in_ready) begin
        q16.push_back('{ref_mul(s_in_op, {48'd0, s_in_a}, {48'd0, s_in_b}, 16), s_in_tag});
        n_acc16++;
      end
      h16_v   = s_out_valid && !s_out_ready;
      h16_res = s_out_result;
      h16_tag = s_out_tag;
    end
  end

  task automatic run_one(input string nm, input mul_op_e op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag, input logic [63:0] exp);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq({nm, "_early"}, 64'(out_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    check_eq({nm, "_vld"}, 64'(out_valid), 64'd1);
    check_eq({nm, "_res"}, out_result, exp);
    check_eq({nm, "_tag"}, 64'(out_tag), 64'(tag));
  endtask

  task automatic stream(input int n, input int stall_at);
    int sent;
    int cyc;
    logic acc;
    sent = 0;
    cyc  = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = OP_MULHU; in_a = rnd_opnd(64); in_b = rnd_opnd(64); in_tag = 5'd0;
    while (sent < n && cyc < 200) begin
      @(negedge clk);
      if (out_valid && !out_ready) check_eq("stall_in_ready", 64'(in_ready), 64'd0);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
      out_ready = !(cyc >= stall_at && cyc < stall_at + 4);
      in_valid  = (sent < n);
      in_op     = mul_op_e'($urandom_range(0, 3));
      in_a      = rnd_opnd(64);
      in_b      = rnd_opnd(64);
      in_tag    = 5'(sent);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("stream_sent", 64'(sent), 64'(n));
  endtask

  task automatic drain();
    int c;
    c = 0;
    in_valid = 1'b0; s_in_valid = 1'b0;
    out_ready = 1'b1; s_out_ready = 1'b1;
    while ((q64.size() != 0 || q16.size() != 0) && c < 100) begin
      @(posedge clk);
      c++;
    end
    @(negedge clk);
    check_eq("drain64", 64'(q64.size()), 64'd0);
    check_eq("drain16", 64'(q16.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_op = OP_MUL; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_op = OP_MUL; s_in_a = '0; s_in_b = '0; s_in_tag = '0; s_out_ready = 1'b1;
`ifdef BOOTH_MUL_FLUSH_EN
    flush = 1'b0; s_flush = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_result", out_result, 64'd0);
    check_eq("rst_out_tag", 64'(out_tag), 64'd0);
    check_eq("rst_out_valid16", 64'(s_out_valid), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    run_one("mul_3x5", OP_MUL, 64'd3, 64'd5, 5'd17, 64'd15);
    run_one("mulh_m1", OP_MULH, '1, '1, 5'd1, 64'd0);
    run_one("mulhu_m1", OP_MULHU, '1, '1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    run_one("mulhsu_m1x2", OP_MULHSU, '1, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    run_one("mulh_min", OP_MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd4,
            64'h4000_0000_0000_0000);

    // 8 back-to-back ops: one result per cycle, in tag order
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = OP_MUL; in_a = 64'd1; in_b = 64'd3; in_tag = 5'd0;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      if (j + 1 < 8) begin
        in_a = 64'(j + 2); in_tag = 5'(j + 1);
      end else in_valid = 1'b0;
      @(negedge clk);
      if (j >= 2) begin
        check_eq("burst_vld", 64'(out_valid), 64'd1);
        check_eq("burst_tag", 64'(out_tag), 64'(j - 2));
      end
    end

    stream(12, 5);
    drain();

    // reset with three ops in flight
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = OP_MUL; in_a = 64'd11; in_b = 64'd2; in_tag = 5'd20;
    @(posedge clk); #1 in_tag = 5'd21;
    @(posedge clk); #1 in_tag = 5'd22;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("postrst_idle", 64'(out_valid), 64'd0);
    run_one("post_rst_7x9", OP_MUL, 64'd7, 64'd9, 5'd12, 64'd63);

`ifdef BOOTH_MUL_FLUSH_EN
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = OP_MUL; in_a = 64'd4; in_b = 64'd4; in_tag = 5'd5;
    @(posedge clk); #1 in_tag = 5'd6;
    @(posedge clk); #1;
    in_tag = 5'd7;
    flush = 1'b1;
    @(negedge clk);
    check_eq("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    run_one("post_flush", OP_MUL, 64'd2, 64'd3, 5'd8, 64'd6);
`endif

    n_acc64 = 0;
    n_acc16 = 0;
    fork
      begin
        int cyc;
        cyc = 0;
        while (n_acc64 < NRAND && cyc < 40000) begin
          @(posedge clk); #1;
          in_valid  = ($urandom_range(0, 3) != 0);
          in_op     = mul_op_e'($urandom_range(0, 3));
          in_a      = rnd_opnd(64);
          in_b      = rnd_opnd(64);
          in_tag    = 5'($urandom);
          out_ready = ($urandom_range(0, 3) != 0);
          cyc++;
        end
        @(posedge clk); #1 in_valid = 1'b0;
      end
      begin
        int cyc;
        cyc = 0;
        while (n_acc16 < NRAND && cyc < 40000) begin
          @(posedge clk); #1;
          s_in_valid  = ($urandom_range(0, 3) != 0);
          s_in_op     = mul_op_e'($urandom_range(0, 3));
          s_in_a      = 16'(rnd_opnd(16));
          s_in_b      = 16'(rnd_opnd(16));
          s_in_tag    = 5'($urandom);
          s_out_ready = ($urandom_range(0, 3) != 0);
          cyc++;
        end
        @(posedge clk); #1 s_in_valid = 1'b0;
      end
    join
    check_eq("rand64_done", 64'(n_acc64 >= NRAND), 64'd1);
    check_eq("rand16_done", 64'(n_acc16 >= NRAND), 64'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
